vx_xbar_credit_sched: RTL and testbench

//   Credit-based scheduler in front of the stream crossbar fabric. Each input carries one request and a

---
 rtl/vx_xbar_pkg.sv | 44 ++++
 rtl/vx_xbar_credit_port.sv | 85 ++++++++
 rtl/vx_xbar_credit_sched.sv | 93 +++++++++
 tb/tb_vx_xbar_credit_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vx_xbar_pkg.sv
// Shared types and the round-robin pick helper for the credit-based crossbar scheduler.
package vx_xbar_pkg;

    localparam int unsigned NUM_INPUTS  = 4;
    localparam int unsigned NUM_OUTPUTS = 4;
    localparam int unsigned DATAW       = 32;
    localparam int unsigned CREDITS     = 4;
    localparam int unsigned IN_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned OUT_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1;
    localparam int unsigned CREDITW     = $clog2(CREDITS + 1);

    typedef logic [IN_WIDTH-1:0]  in_idx_t;
    typedef logic [OUT_WIDTH-1:0] out_idx_t;
    typedef logic [CREDITW-1:0]   credit_t;

    // The pick helper works on a fixed-width request vector so any NI up to MAX_NI can share it.
    localparam int unsigned MAX_NI   = 32;
    localparam int unsigned MAX_IDXW = 5;

    typedef struct packed {
        logic                valid;
        logic [MAX_IDXW-1:0] idx;
    } rr_pick_t;

    // First set bit of req at or after ptr, wrapping at ni.
    function automatic rr_pick_t rr_pick(input logic [MAX_NI-1:0]   req,
                                         input logic [MAX_IDXW-1:0] ptr,
                                         input int unsigned         ni = NUM_INPUTS);
        rr_pick_t    r;
        int unsigned k;
        r = '0;
        for (int unsigned j = 0; j < MAX_NI; j++) begin
            if (!r.valid && (j < ni)) begin
                k = (32'(ptr) + j) % ni;
                if (req[k]) begin
                    r.valid = 1'b1;
                    r.idx   = k[MAX_IDXW-1:0];
                end
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/vx_xbar_credit_port.sv
// One output of the scheduler: round-robin pointer, downstream credit counter and output register.
module vx_xbar_credit_port
    import vx_xbar_pkg::*;
#(
    parameter int unsigned NI       = 4,
    parameter int unsigned DATAW    = 32,
    parameter int unsigned CREDITS  = 4,
    parameter int unsigned IN_WIDTH = 2,
    parameter int unsigned CREDITW  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NI-1:0]        i_cand,
    input  logic [NI*DATAW-1:0]  i_data,
    input  logic                 i_ready_out,
    input  logic                 i_credit_ret,
    output logic [NI-1:0]        o_grant,
    output logic                 o_valid,
    output logic [DATAW-1:0]     o_data,
    output logic [IN_WIDTH-1:0]  o_sel,
    output logic [CREDITW-1:0]   o_credits,
    output logic                 o_stall
);

    logic [IN_WIDTH-1:0] r_ptr;
    logic [CREDITW-1:0]  r_credit;
    logic                r_valid;
    logic [DATAW-1:0]    r_data;
    logic [IN_WIDTH-1:0] r_sel;

    rr_pick_t            w_pick;
    logic                w_unused_pick;
    logic                w_free;
    logic                w_grant_en;
    logic [IN_WIDTH-1:0] w_win;

    always_comb begin
        w_pick     = rr_pick(MAX_NI'(i_cand), MAX_IDXW'(r_ptr), NI);
        w_win      = w_pick.idx[IN_WIDTH-1:0];
        w_free     = !r_valid || i_ready_out;
        // A return arriving at zero credit is only usable from the next cycle.
        w_grant_en = w_pick.valid && (r_credit != '0) && w_free;
        o_grant    = '0;
        if (w_grant_en) begin
            o_grant[w_win] = 1'b1;
        end
    end

    assign w_unused_pick = ^w_pick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr    <= '0;
            r_credit <= CREDITW'(CREDITS);
            r_valid  <= 1'b0;
            r_data   <= '0;
            r_sel    <= '0;
        end else begin
            if (w_grant_en) begin
                r_valid <= 1'b1;
                r_data  <= i_data[w_win*DATAW +: DATAW];
                r_sel   <= w_win;
                r_ptr   <= (w_win == IN_WIDTH'(NI - 1)) ? '0 : w_win + 1'b1;
            end else if (i_ready_out) begin
                r_valid <= 1'b0;
            end

            if (w_grant_en && !i_credit_ret) begin
                r_credit <= r_credit - 1'b1;
            end else if (!w_grant_en && i_credit_ret && (r_credit != CREDITW'(CREDITS))) begin
                r_credit <= r_credit + 1'b1;
            end
        end
    end

    a_credit_overflow: assert property (@(posedge clk) disable iff (reset)
        !(i_credit_ret && !w_grant_en && (r_credit == CREDITW'(CREDITS))));

    assign o_valid   = r_valid;
    assign o_data    = r_data;
    assign o_sel     = r_sel;
    assign o_credits = r_credit;
    assign o_stall   = (|i_cand) && (r_credit == '0);

endmodule

// File: rtl/vx_xbar_credit_sched.sv
// Credit-based round-robin scheduler in front of the crossbar fabric.
// Optional stall counter port perf_stalls when XBAR_CREDIT_PERF_EN is defined.
module vx_xbar_credit_sched
    import vx_xbar_pkg::*;
#(
    parameter int unsigned NUM_INPUTS  = 4,
    parameter int unsigned NUM_OUTPUTS = 4,
    parameter int unsigned DATAW       = 32,
    parameter int unsigned CREDITS     = 4,
    parameter int unsigned IN_WIDTH    = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
    parameter int unsigned OUT_WIDTH   = (NUM_OUTPUTS > 1) ? $clog2(NUM_OUTPUTS) : 1,
    parameter int unsigned CREDITW     = $clog2(CREDITS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_INPUTS-1:0]           valid_in,
    input  logic [NUM_INPUTS*DATAW-1:0]     data_in,
    input  logic [NUM_INPUTS*OUT_WIDTH-1:0] sel_in,
    output logic [NUM_INPUTS-1:0]           ready_in,
    output logic [NUM_OUTPUTS-1:0]          valid_out,
    output logic [NUM_OUTPUTS*DATAW-1:0]    data_out,
    output logic [NUM_OUTPUTS*IN_WIDTH-1:0] sel_out,
    input  logic [NUM_OUTPUTS-1:0]          ready_out,
    input  logic [NUM_OUTPUTS-1:0]          credit_ret,
    output logic [NUM_OUTPUTS*CREDITW-1:0]  credits_avail
`ifdef XBAR_CREDIT_PERF_EN
    ,
    output logic [31:0]                     perf_stalls
`endif
);

    logic [NUM_INPUTS-1:0]  w_cand  [NUM_OUTPUTS];
    logic [NUM_INPUTS-1:0]  w_grant [NUM_OUTPUTS];
    logic [NUM_OUTPUTS-1:0] w_stall;

    always_comb begin
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            for (int i = 0; i < NUM_INPUTS; i++) begin
                w_cand[o][i] = valid_in[i] && ((NUM_OUTPUTS == 1) ||
                               (sel_in[i*OUT_WIDTH +: OUT_WIDTH] == OUT_WIDTH'(o)));
            end
        end
    end

    // Each input targets one output, so at most one port can grant it.
    always_comb begin
        ready_in = '0;
        for (int o = 0; o < NUM_OUTPUTS; o++) begin
            ready_in = ready_in | w_grant[o];
        end
    end

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_port
        vx_xbar_credit_port #(
            .NI       (NUM_INPUTS),
            .DATAW    (DATAW),
            .CREDITS  (CREDITS),
            .IN_WIDTH (IN_WIDTH),
            .CREDITW  (CREDITW)
        ) u_port (
            .clk          (clk),
            .reset        (reset),
            .i_cand       (w_cand[g]),
            .i_data       (data_in),
            .i_ready_out  (ready_out[g]),
            .i_credit_ret (credit_ret[g]),
            .o_grant      (w_grant[g]),
            .o_valid      (valid_out[g]),
            .o_data       (data_out[g*DATAW +: DATAW]),
            .o_sel        (sel_out[g*IN_WIDTH +: IN_WIDTH]),
            .o_credits    (credits_avail[g*CREDITW +: CREDITW]),
            .o_stall      (w_stall[g])
        );
    end

`ifdef XBAR_CREDIT_PERF_EN
    logic [31:0] r_perf_stalls;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_perf_stalls <= '0;
        end else if (|w_stall) begin
            r_perf_stalls <= r_perf_stalls + 32'd1;
        end
    end

    assign perf_stalls = r_perf_stalls;
`else
    logic w_unused_stall;
    assign w_unused_stall = ^w_stall;
`endif

endmodule

// File: tb/tb_vx_xbar_credit_sched.sv
// Self-checking bench for vx_xbar_credit_sched: directed scenarios plus random traffic against a
// transaction-level model of the grant, credit and output-register rules.
module tb_vx_xbar_credit_sched;

    localparam int NI = 4;
    localparam int NO = 4;
    localparam int DW = 32;
    localparam int CR = 4;
    localparam int IW = 2;
    localparam int OW = 2;
    localparam int CW = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic [NI-1:0]      valid_in;
    logic [NI*DW-1:0]   data_in;
    logic [NI*OW-1:0]   sel_in;
    logic [NI-1:0]      ready_in;
    logic [NO-1:0]      valid_out;
    logic [NO*DW-1:0]   data_out;
    logic [NO*IW-1:0]   sel_out;
    logic [NO-1:0]      ready_out;
    logic [NO-1:0]      credit_ret;
    logic [NO*CW-1:0]   credits_avail;
`ifdef XBAR_CREDIT_PERF_EN
    logic [31:0]        perf_stalls;
`endif

    always #5 clk = ~clk;

    vx_xbar_credit_sched dut (
        .clk           (clk),
        .reset         (reset),
        .valid_in      (valid_in),
        .data_in       (data_in),
        .sel_in        (sel_in),
        .ready_in      (ready_in),
        .valid_out     (valid_out),
        .data_out      (data_out),
        .sel_out       (sel_out),
        .ready_out     (ready_out),
        .credit_ret    (credit_ret),
        .credits_avail (credits_avail)
`ifdef XBAR_CREDIT_PERF_EN
        ,
        .perf_stalls   (perf_stalls)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: what each output holds and how many credits it has.
    int          m_credit [NO];
    int          m_ptr    [NO];
    bit          m_vld    [NO];
    logic [31:0] m_data   [NO];
    int          m_sel    [NO];
    int          m_stalls;

    task automatic do_reset();
        reset      = 1'b1;
        valid_in   = '0;
        sel_in     = '0;
        data_in    = '0;
        ready_out  = '0;
        credit_ret = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int o = 0; o < NO; o++) begin
            m_credit[o] = CR;
            m_ptr[o]    = 0;
            m_vld[o]    = 1'b0;
            m_data[o]   = '0;
            m_sel[o]    = 0;
        end
        m_stalls = 0;
    endtask

    // Called just after a falling edge; applies one cycle of stimulus and returns at the next one.
    task automatic run_cycle(input logic [NI-1:0] v, input logic [NI*OW-1:0] s,
                             input logic [NO-1:0] rdy, input logic [NO-1:0] ret_req);
        int            win [NO];
        logic [NI-1:0] exp_rdy;
        logic [NO-1:0] ret;
        bit            stall;
        bit            any_req;
        int            idx;
        valid_in  = v;
        sel_in    = s;
        ready_out = rdy;
        for (int k = 0; k < NI; k++) data_in[k*DW +: DW] = $urandom;
        exp_rdy = '0;
        stall   = 1'b0;
        for (int o = 0; o < NO; o++) begin
            any_req = 1'b0;
            win[o]  = -1;
            for (int k = 0; k < NI; k++) begin
                idx = (m_ptr[o] + k) % NI;
                if (v[idx] && (int'(s[idx*OW +: OW]) == o)) begin
                    any_req = 1'b1;
                    if (win[o] < 0) win[o] = idx;
                end
            end
            if (any_req && m_credit[o] == 0) stall = 1'b1;
            if (m_credit[o] == 0 || (m_vld[o] && !rdy[o])) win[o] = -1;
            if (win[o] >= 0) exp_rdy[win[o]] = 1'b1;
            ret[o] = ret_req[o] && (m_credit[o] < CR || win[o] >= 0);
        end
        credit_ret = ret;
        #1;
        check_val("ready_in", 64'(ready_in), 64'(exp_rdy));
        for (int o = 0; o < NO; o++) begin
            check_val($sformatf("valid_out%0d", o), 64'(valid_out[o]), 64'(m_vld[o]));
            check_val($sformatf("credits%0d", o), 64'(credits_avail[o*CW +: CW]),
                      64'(m_credit[o]));
            if (m_vld[o]) begin
                check_val($sformatf("data_out%0d", o), 64'(data_out[o*DW +: DW]),
                          64'(m_data[o]));
                check_val($sformatf("sel_out%0d", o), 64'(sel_out[o*IW +: IW]), 64'(m_sel[o]));
            end
        end
        for (int o = 0; o < NO; o++) begin
            if (win[o] >= 0) begin
                m_vld[o]  = 1'b1;
                m_data[o] = data_in[win[o]*DW +: DW];
                m_sel[o]  = win[o];
                m_ptr[o]  = (win[o] + 1) % NI;
            end else if (rdy[o]) begin
                m_vld[o] = 1'b0;
            end
            m_credit[o] = m_credit[o] - ((win[o] >= 0) ? 1 : 0) + (ret[o] ? 1 : 0);
            if (m_credit[o] > CR) m_credit[o] = CR;
        end
        if (stall) m_stalls++;
        @(negedge clk);
    endtask

    initial begin
        int          beats;
        logic [31:0] held;
        @(negedge clk);
        do_reset();

        // Reset state with idle inputs
        #1;
        check_val("rst_valid", 64'(valid_out), 64'd0);
        check_val("rst_credits", 64'(credits_avail), 64'({NO{3'd4}}));
        check_val("rst_ready", 64'(ready_in), 64'd0);
        check_val("rst_sel", 64'(sel_out), 64'd0);
        check_val("rst_data", 64'(|data_out), 64'd0);
        @(negedge clk);
        run_cycle('0, '0, '1, '0);

        // All inputs to output 1, credits echoed
        for (int k = 0; k < 5; k++) begin
            run_cycle(4'hf, 8'h55, 4'hf, 4'b0010);
            check_val("t2_sel", 64'(sel_out[1*IW +: IW]), 64'(k % 4));
            check_val("t2_others", 64'(valid_out & 4'b1101), 64'd0);
        end

        // Input 2 to output 0 without returns: credits run out
        do_reset();
        beats = 0;
        repeat (6) begin
            run_cycle(4'b0100, 8'h00, 4'b0001, 4'b0000);
            beats += int'(valid_out[0]);
        end
        check_val("t3_beats", 64'(beats), 64'd4);
        check_val("t3_credits", 64'(credits_avail[0 +: CW]), 64'd0);
        check_val("t3_ready", 64'(ready_in[2]), 64'd0);
        run_cycle(4'b0100, 8'h00, 4'b0001, 4'b0001);
        check_val("t3_ret_nogrant", 64'(valid_out[0]), 64'd0);
        run_cycle(4'b0100, 8'h00, 4'b0001, 4'b0000);
        check_val("t3_extra_beat", 64'(valid_out[0]), 64'd1);

        // Grant plus return at credit 1; return at credit 0 refused that cycle
        run_cycle(4'b0000, 8'h00, 4'b0001, 4'b0001);
        run_cycle(4'b0100, 8'h00, 4'b0001, 4'b0001);
        check_val("t4_credit_hold", 64'(credits_avail[0 +: CW]), 64'd1);
        run_cycle(4'b0100, 8'h00, 4'b0001, 4'b0000);
        run_cycle(4'b0100, 8'h00, 4'b0001, 4'b0001);
        check_val("t4_zero_nogrant", 64'(valid_out[0]), 64'd0);
        run_cycle(4'b0100, 8'h00, 4'b0001, 4'b0000);
        check_val("t4_next_grant", 64'(valid_out[0]), 64'd1);

        // Output 3 back-pressured with its register full
        do_reset();
        run_cycle(4'b1000, 8'hc0, 4'b0000, 4'b0000);
        held = data_out[3*DW +: DW];
        repeat (5) begin
            run_cycle(4'b1000, 8'hc0, 4'b0000, 4'b0000);
            check_val("t5_hold_data", 64'(data_out[3*DW +: DW]), 64'(held));
            check_val("t5_hold_valid", 64'(valid_out[3]), 64'd1);
        end
        run_cycle(4'b1000, 8'hc0, 4'b1000, 4'b0000);
        check_val("t5_regrant", 64'(valid_out[3]), 64'd1);
        check_val("t5_credits", 64'(credits_avail[3*CW +: CW]), 64'd2);

        // One input per output, all in parallel
        do_reset();
        run_cycle(4'hf, 8'he4, 4'hf, 4'h0);
        check_val("t6_all_valid", 64'(valid_out), 64'hf);

        // Output 0 out of credit for 3 requested cycles
        do_reset();
        repeat (7) run_cycle(4'b0001, 8'h00, 4'hf, 4'h0);
`ifdef XBAR_CREDIT_PERF_EN
        check_val("t6_perf", 64'(perf_stalls), 64'd3);
`endif
        check_val("t6_stall_model", 64'(m_stalls), 64'd3);

        // Random traffic, with a reset in the middle of it
        do_reset();
        for (int n = 0; n < 800; n++) begin
            if (n == 400) do_reset();
            run_cycle(4'($urandom), 8'($urandom), 4'($urandom) | 4'($urandom),
                      4'($urandom));
        end
`ifdef XBAR_CREDIT_PERF_EN
        check_val("perf_random", 64'(perf_stalls), 64'(m_stalls));
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
